// File: rtl/lif_potential_integrator.sv
// lif_potential_integrator: leaky integrate-and-fire stage that turns MAC weight sums into addressed spikes
module lif_potential_integrator #(
    parameter logic [11:0] NEURON_ADDRESS   = 12'd0,
    parameter logic [31:0] V_THRESHOLD      = 32'h42C80000,
    parameter logic [31:0] V_RESET          = 32'h00000000,
    parameter int          LEAK_SHIFT       = 1,
    parameter int          REFRACTORY_STEPS = 2
) (
    input  logic        CLK_Neuron,
    input  logic        RST_Neuron,
    input  logic [31:0] weight_in,
    input  logic        weight_valid,
    output logic        spike_out,
    output logic [11:0] spike_address,
    output logic [31:0] potential_out,
    output logic        busy,
    output logic        overrun
);
    typedef enum logic [1:0] {S_IDLE, S_LEAK, S_ADD, S_CMP} state_t;
    localparam logic [7:0] LEAK_EXP  = 8'(LEAK_SHIFT);
    localparam logic [7:0] REFR_INIT = 8'(REFRACTORY_STEPS);
    state_t state, state_n;
    logic valid_q, sample_edge, skip, fire, a_big, sub;
    logic [7:0] refr;
    logic [31:0] potential, sample, leaked, sum, lg, sm;
    logic [23:0] ml, ms;
    logic [24:0] mx;
    logic [22:0] mn;
    logic [4:0] lz;
    assign sample_edge   = weight_valid & ~valid_q;
    assign busy          = state != S_IDLE;
    assign potential_out = potential;
    // leak by exponent decrement, flushing to +0 once the exponent would reach zero
    always_comb begin
        leaked = potential[30:23] <= LEAK_EXP ? 32'd0 : {potential[31], potential[30:23] - LEAK_EXP, potential[22:0]};
        fire   = !potential[31] && potential[30:0] >= V_THRESHOLD[30:0];
    end
    // single-cycle truncating float add of the leaked potential and the captured sample
    always_comb begin
        a_big = potential[30:0] >= sample[30:0];
        lg    = a_big ? potential : sample;
        sm    = a_big ? sample : potential;
        ml    = lg[30:23] != 8'd0 ? {1'b1, lg[22:0]} : 24'd0;
        ms    = (sm[30:23] != 8'd0 ? {1'b1, sm[22:0]} : 24'd0) >> (lg[30:23] - sm[30:23]);
        sub   = lg[31] ^ sm[31];
        mx    = sub ? {1'b0, ml} - {1'b0, ms} : {1'b0, ml} + {1'b0, ms};
        lz    = 5'd0;
        for (int i = 0; i < 24; i++) if (mx[i]) lz = 5'(23 - i);
        mn    = 23'(mx[23:0] << lz);
        sum   = lg[30:23] == 8'hFF ? {lg[31], 31'h7F7FFFFF} :
                mx == 25'd0 ? 32'd0 :
                mx[24] ? (lg[30:23] == 8'hFE ? {lg[31], 31'h7F7FFFFF} : {lg[31], lg[30:23] + 8'd1, mx[23:1]}) :
                {3'b000, lz} >= lg[30:23] ? 32'd0 : {lg[31], lg[30:23] - {3'b000, lz}, mn};
    end
    // timestep sequencer: capture, leak, add, compare
    always_comb begin
        state_n = state == S_IDLE ? (sample_edge ? S_LEAK : S_IDLE) :
                  state == S_LEAK ? S_ADD :
                  state == S_ADD  ? S_CMP : S_IDLE;
    end
    // state register
    always_ff @(posedge CLK_Neuron or posedge RST_Neuron) begin
        if (RST_Neuron) state <= S_IDLE;
        else state <= state_n;
    end
    // membrane potential, refractory countdown, spike pulse and overrun flag
    always_ff @(posedge CLK_Neuron or posedge RST_Neuron) begin
        if (RST_Neuron) begin
            valid_q       <= 1'b0;
            spike_out     <= 1'b0;
            spike_address <= 12'd0;
            overrun       <= 1'b0;
            potential     <= 32'd0;
            sample        <= 32'd0;
            skip          <= 1'b0;
            refr          <= 8'd0;
        end else begin
            valid_q       <= weight_valid;
            spike_out     <= 1'b0;
            spike_address <= 12'd0;
            if (sample_edge && busy) overrun <= 1'b1;
            if (sample_edge && !busy) begin
                sample <= weight_in;
                skip   <= refr != 8'd0;
                if (refr != 8'd0) refr <= refr - 8'd1;
            end
            if (!skip && state == S_LEAK) potential <= leaked;
            if (!skip && state == S_ADD) potential <= sum;
            if (!skip && state == S_CMP && fire) begin
                spike_out     <= 1'b1;
                spike_address <= NEURON_ADDRESS;
                potential     <= V_RESET;
                refr          <= REFR_INIT;
            end
        end
    end
endmodule

// File: tb/tb_lif_potential_integrator.sv
// tb_lif_potential_integrator: scoreboard bench with directed timesteps and a real-valued neuron model
module tb_lif_potential_integrator;
    localparam logic [11:0] ADDR = 12'hA5C;
    typedef struct {logic spike; logic [31:0] pot;} exp_t;
    logic clk = 1'b0, rst = 1'b1, weight_valid = 1'b0, busy_d = 1'b0;
    logic [31:0] weight_in = 32'd0;
    logic spike_out, busy, overrun;
    logic [11:0] spike_address;
    logic [31:0] potential_out;
    exp_t exp_q[$];
    exp_t e;
    int checks = 0, errors = 0, mref = 0;
    real mp = 0.0;

    lif_potential_integrator #(.NEURON_ADDRESS(ADDR)) dut (
        .CLK_Neuron(clk), .RST_Neuron(rst), .weight_in(weight_in), .weight_valid(weight_valid),
        .spike_out(spike_out), .spike_address(spike_address), .potential_out(potential_out),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] x;
        d = $realtobits(r);
        x = d[62:52] - 11'd896;
        return (r == 0.0) ? 32'd0 : {d[63], x[7:0], d[51:29]};
    endfunction

    // monitor: a busy->idle transition marks the cycle where the timestep result is visible
    always @(negedge clk) begin
        if (rst) busy_d = 1'b0;
        else begin
            if (busy_d && !busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result spike %b pot %h with nothing expected", spike_out, potential_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("spike", 32'(spike_out), 32'(e.spike));
                    chk("spike_address", 32'(spike_address), e.spike ? 32'(ADDR) : 32'd0);
                    chk("potential", potential_out, e.pot);
                end
            end else chk("idle_spike", {19'd0, spike_out, spike_address}, 32'd0);
            busy_d = busy;
        end
    end

    task automatic send(input logic [31:0] w, input logic sp, input logic [31:0] pot);
        @(negedge clk);
        weight_in = w;
        weight_valid = 1'b1;
        exp_q.push_back('{sp, pot});
        @(negedge clk);
        weight_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL lost_result pending %0d want 0", exp_q.size());
        end
        rst = 1'b1;
        weight_valid = 1'b0;
        exp_q.delete();
        mp = 0.0;
        mref = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // reference neuron: halve, add, fire at 100.0, then ignore two timesteps
    task automatic rand_step();
        int w;
        logic sp;
        w = int'($urandom_range(255, 0)) - 64;
        sp = 1'b0;
        if (mref > 0) mref--;
        else begin
            mp = mp / 2.0 + real'(w);
            if (mp >= 100.0) begin
                sp = 1'b1;
                mp = 0.0;
                mref = 2;
            end
        end
        send(r2f(real'(w)), sp, r2f(mp));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout no finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("rst_spike", {19'd0, spike_out, spike_address}, 32'd0);
        chk("rst_busy_overrun", {30'd0, busy, overrun}, 32'd0);
        chk("rst_potential", potential_out, 32'd0);
        rst = 1'b0;
        send(32'h42800000, 1'b0, 32'h42800000);
        send(32'h42800000, 1'b0, 32'h42C00000);
        send(32'h42800000, 1'b1, 32'h00000000);
        send(32'h43480000, 1'b0, 32'h00000000);
        send(32'h43480000, 1'b0, 32'h00000000);
        send(32'h43480000, 1'b1, 32'h00000000);
        do_reset();
        send(32'h42800000, 1'b0, 32'h42800000);
        send(32'hC2000000, 1'b0, 32'h00000000);
        send(32'hC2800000, 1'b0, 32'hC2800000);
        send(32'h42800000, 1'b0, 32'h42000000);
        send(32'hFF800000, 1'b0, 32'hFF7FFFFF);
        send(32'hFF7FFFFF, 1'b0, 32'hFF7FFFFF);
        do_reset();
        send(32'h00400000, 1'b0, 32'h00000000);
        send(32'h80400000, 1'b0, 32'h00000000);
        @(negedge clk);
        weight_in = 32'h42800000;
        weight_valid = 1'b1;
        exp_q.push_back('{1'b0, 32'h42800000});
        repeat (8) @(negedge clk);
        weight_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_no_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        weight_in = 32'h42800000;
        weight_valid = 1'b1;
        exp_q.push_back('{1'b0, 32'h42C00000});
        @(negedge clk);
        weight_valid = 1'b0;
        @(negedge clk);
        weight_in = 32'h43480000;
        weight_valid = 1'b1;
        @(negedge clk);
        weight_valid = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        send(32'h42800000, 1'b1, 32'h00000000);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        do_reset();
        chk("overrun_cleared", 32'(overrun), 32'd0);
        send(32'h42800000, 1'b0, 32'h42800000);
        @(negedge clk);
        weight_in = 32'h43480000;
        weight_valid = 1'b1;
        @(negedge clk);
        weight_valid = 1'b0;
        @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        chk("abort_pre_pot", potential_out, 32'h42000000);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pot", potential_out, 32'd0);
        chk("abort_spike", {19'd0, spike_out, spike_address}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        for (int ep = 0; ep < 30; ep++) begin
            int n;
            do_reset();
            n = int'($urandom_range(10, 3));
            for (int k = 0; k < n; k++) rand_step();
        end
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
